// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Multi-port register file with a per-register busy scoreboard.
//            Two synchronous write ports and NUM_RD combinational read ports.
//            Register 0 is hardwired to zero and can never be marked busy.
//            A register is reserved (busy) at issue and cleared when a write
//            port writes it back. If a register is set and cleared on the
//            same edge, the set wins.
// Optional : REGFILE_BYPASS_EN - when defined, a write in the current cycle
//            is forwarded to matching read ports. Port 1 has priority, which
//            matches the write-conflict rule.
// Ports    : clk                   - clock; all state updates on rising edge
//            reset                 - asynchronous, active-high clear
//            we0/waddr0/wdata0     - write port 0
//            we1/waddr1/wdata1     - write port 1 (wins on same address)
//            raddr [NUM_RD*ADDR_W] - packed read addresses, port k at k*ADDR_W
//            rdata [NUM_RD*DATA_W] - packed read data, port k at k*DATA_W
//            rsv_en/rsv_addr       - reserve (mark busy) a register
//            rd_busy [NUM_RD]      - busy flag of each read port's register
//            busy_vec [2**ADDR_W]  - full scoreboard
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [(2**ADDR_W)-1:0]   busy_vec
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    // Next array contents. Port 1 is applied last so it wins a same-address
    // conflict. Entry 0 is forced to zero so it is never anything but zero.
    always_comb begin : p_mem_next
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (we0 && (waddr0 != '0)) begin
            mem_d[waddr0] = wdata0;
        end
        if (we1 && (waddr1 != '0)) begin
            mem_d[waddr1] = wdata1;
        end
        mem_d[0] = '0;
    end

    // Scoreboard next state: writeback clears first, then a reservation
    // sets, so a set and a clear of the same register on one edge leaves it busy.
    always_comb begin : p_busy_next
        busy_d = busy_q;
        if (we0) begin
            busy_d[waddr0] = 1'b0;
        end
        if (we1) begin
            busy_d[waddr1] = 1'b0;
        end
        if (rsv_en) begin
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin : p_state
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] raddr_k;
        logic [DATA_W-1:0] rdata_k;

        assign raddr_k = raddr[k*ADDR_W +: ADDR_W];

        // mem_q[0] is always zero, so an address-0 read needs no special case
        // unless forwarding is enabled. Forwarding is suppressed during reset
        // so that the outputs read zero while reset is held.
        always_comb begin : p_read
            rdata_k = mem_q[raddr_k];
`ifdef REGFILE_BYPASS_EN
            if (!reset && (raddr_k != '0)) begin
                if (we1 && (waddr1 == raddr_k)) begin
                    rdata_k = wdata1;
                end else if (we0 && (waddr0 == raddr_k)) begin
                    rdata_k = wdata0;
                end
            end
`else
`endif
        end

        assign rdata[k*DATA_W +: DATA_W] = rdata_k;
        // Busy reflects registered state only and ignores same-cycle clears.
        assign rd_busy[k] = busy_q[raddr_k];
    end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file, the next generation of the datapath register bank. Provides two synchronous write ports, NUM_RD combinational read ports and a register 0 hardwired to zero. Adds a per-register busy scoreboard, reserved at issue and cleared at writeback, so the control unit can detect RAW hazards. Sits between decode (read and reserve) and writeback (write ports) in the pipelined CPU.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W registers
NUM_RD, 2, number of read ports (1..4)

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high; clears all registers and the scoreboard
we0  in  1  write enable, port 0
waddr0  in  ADDR_W  write address, port 0
wdata0  in  DATA_W  write data, port 0
we1  in  1  write enable, port 1
waddr1  in  ADDR_W  write address, port 1
wdata1  in  DATA_W  write data, port 1
raddr  in  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W]
rsv_en  in  1  reserve (mark busy) the register at rsv_addr
rsv_addr  in  ADDR_W  register to reserve
rd_busy  out  NUM_RD  busy flag of the register addressed by each read port
busy_vec  out  2**ADDR_W  full scoreboard; bit i is the busy flag of register i

Behaviour:
- Reset (async, active-high): all registers become 0 and all busy bits become 0 immediately. While reset is high: rdata = 0, rd_busy = 0, busy_vec = 0. Writes and reservations are ignored. Reset mid-operation drops any in-flight write or reserve for that edge.
- Register 0:
  - Reads always return 0 and its busy bit always reads 0.
  - Writes to address 0 are discarded.
  - Reserving address 0 is a no-op.
- Writes: on posedge clk, reg[waddrN] <= wdataN when weN=1 and waddrN!=0. Latency is 1 cycle: the value is visible through the array on the cycle after the edge.
- Write conflict: if we0=we1=1 and waddr0==waddr1!=0, port 1 wins. Port 0 data is dropped.
- Reads are combinational from the array, with no read latency. Each port resolves independently; duplicate addresses across read ports are legal.
- Scoreboard, per register i != 0, on posedge clk:
  - set when rsv_en=1 and rsv_addr==i;
  - cleared when a write port writes i (weN=1, waddrN==i);
  - set and clear on the same edge for the same i: set wins (a newer instruction has reserved it);
  - clearing a register that is not busy is legal and has no effect;
  - re-reserving a register that is already busy keeps it busy;
  - two write ports clearing the same register is legal.
- rd_busy[k] = busy_vec[raddr_k], combinational. It ignores same-cycle clears even when the bypass is enabled: busy reflects registered state only.
- The block has no handshake and never stalls. Hazard decisions belong to control.
- Width rules: there is no arithmetic. Addresses are always in range (depth = 2**ADDR_W), so no address wrap or out-of-range case exists.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. For read port k with raddr_k!=0:
  - if we1=1 and waddr1==raddr_k, rdata_k = wdata1;
  - else if we0=1 and waddr0==raddr_k, rdata_k = wdata0;
  - else the array value.
  Port 1 priority matches the conflict rule, so forwarded data always equals the value stored at the next edge. Address 0 always reads 0.
- Not defined: reads return only the array contents, so a same-cycle write is seen one cycle later.

Test Plan:
1. Assert reset after arbitrary writes and reservations -> every rdata = 0 and busy_vec = 0 immediately, before any clock edge.
2. we0=1, waddr0=5, wdata0=32'hDEADBEEF, raddr port0 = 5 -> without REGFILE_BYPASS_EN: same cycle 0, next cycle 32'hDEADBEEF; with the macro: 32'hDEADBEEF in the same cycle.
3. we0=we1=1, both to address 7, wdata0=32'h1111_1111, wdata1=32'h2222_2222 -> reg7 = 32'h2222_2222; bypass (if enabled) also returns 32'h2222_2222.
4. Write 32'hFFFF_FFFF to address 0, reserve address 0 -> rdata = 0, busy_vec[0] = 0.
5. rsv_en at 9 -> busy_vec[9] = 1 and rd_busy = 1 for a port reading 9. Later, same edge: we1 to 9 and rsv_en at 9 -> busy stays 1. Next edge: we0 to 9 only -> busy 0.
6. NUM_RD=4, ADDR_W=3, DATA_W=16: fill r1..r7 with 16'h0101*i, read {1,7,7,0} -> 16'h0101, 16'h0707, 16'h0707, 16'h0000.
